// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART host-access memory command sequencer:
// state encodings, memory select codes, ack byte value and the command-frame
// bit layout used by the UART byte receiver when it assembles a command.
package uart_mem_pkg;

    // Raw state codes, kept stable so external debug taps can decode them.
    localparam logic [2:0] IDLE_ENC    = 3'd0;
    localparam logic [2:0] STALL_ENC   = 3'd1;
    localparam logic [2:0] ACCESS_ENC  = 3'd2;
    localparam logic [2:0] RDWAIT_ENC  = 3'd3;
    localparam logic [2:0] TX_SEND_ENC = 3'd4;
    localparam logic [2:0] TX_WAIT_ENC = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = IDLE_ENC,
        STALL   = STALL_ENC,
        ACCESS  = ACCESS_ENC,
        RDWAIT  = RDWAIT_ENC,
        TX_SEND = TX_SEND_ENC,
        TX_WAIT = TX_WAIT_ENC
    } seq_state_t;

    localparam logic MEM_SEL_IMEM = 1'b0;
    localparam logic MEM_SEL_DMEM = 1'b1;

    // Byte returned to the host to acknowledge a completed write.
    localparam logic [7:0] ACK_BYTE = 8'hA5;

    // Command frame layout shared with the receiver: {rw, type, addr, wdata}.
    localparam int CMD_DATA_BITS  = 32;
    localparam int CMD_ADDR_BITS  = 9;
    localparam int CMD_WDATA_LSB  = 0;
    localparam int CMD_ADDR_LSB   = CMD_WDATA_LSB + CMD_DATA_BITS;
    localparam int CMD_TYPE_BIT   = CMD_ADDR_LSB + CMD_ADDR_BITS;
    localparam int CMD_RW_BIT     = CMD_TYPE_BIT + 1;
    localparam int CMD_FRAME_BITS = CMD_RW_BIT + 1;

    // Number of bytes the host receives for one memory word.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_mem_cmd_sequencer_serializer.sv
// uart_word_serializer: holds one word, hands it to the UART transmitter a
// byte at a time (MSB first) and tracks the tx_start / tx_busy handshake.
// The owning FSM tells it which handshake phase it is in and reads back
// when a byte has completed and whether it was the last one.
module uart_word_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic [IDX_BITS-1:0]   load_last,
    input  logic                  send_phase,
    input  logic                  wait_phase,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  byte_sent,
    output logic                  last_byte
);

    logic [DATA_WIDTH-1:0] shift_r;
    logic [IDX_BITS-1:0]   idx_r;
    logic [IDX_BITS-1:0]   last_r;
    logic                  seen_busy_r;  // transmitter acknowledged with tx_busy
    logic                  late_r;       // first post-start cycle already passed

    // Start only into an idle transmitter; data is always the top byte.
    assign tx_start  = send_phase && !tx_busy;
    assign tx_data   = shift_r[DATA_WIDTH-1 -: 8];
    assign last_byte = (idx_r == last_r);

    // A byte is done once busy has risen and fallen, or if busy never rose
    // within two cycles of tx_start (transmitter consumed it silently).
    assign byte_sent = wait_phase && !tx_busy && (seen_busy_r || late_r);

    // Shift register, byte index and handshake tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r     <= '0;
            idx_r       <= '0;
            last_r      <= '0;
            seen_busy_r <= 1'b0;
            late_r      <= 1'b0;
        end else if (load) begin
            shift_r     <= load_word;
            idx_r       <= '0;
            last_r      <= load_last;
            seen_busy_r <= 1'b0;
            late_r      <= 1'b0;
        end else if (tx_start) begin
            seen_busy_r <= 1'b0;
            late_r      <= 1'b0;
        end else if (wait_phase) begin
            if (byte_sent) begin
                shift_r <= shift_r << 8;
                idx_r   <= idx_r + IDX_BITS'(1);
            end else begin
                if (tx_busy) begin
                    seen_busy_r <= 1'b1;
                end
                late_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mem_cmd_sequencer.sv
// uart_mem_cmd_sequencer: buffers one host command from the UART receiver,
// stalls the CPU, performs the access on the shared memory port and, for
// reads, streams the word back through the UART transmitter MSB first.
// Outside a host access the CPU owns the memory port transparently.
// Build option: define UART_SEQ_WRITE_ACK_EN to return ACK_BYTE after writes.
module uart_mem_cmd_sequencer
    import uart_mem_pkg::*;
#(
    parameter int ADDR_BITS    = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int STALL_SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic                  cmd_rw,
    input  logic                  cmd_mem_type,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cpu_mem_en,
    input  logic                  cpu_mem_we,
    input  logic                  cpu_mem_sel,
    input  logic [ADDR_BITS-1:0]  cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    output logic                  cpu_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  err_overflow
);

    localparam int NBYTES   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [1:0] SETTLE_LAST = 2'(STALL_SETTLE - 1);

    seq_state_t state_r;
    seq_state_t state_s;

    logic                  lat_rw_r;
    logic                  lat_sel_r;
    logic [ADDR_BITS-1:0]  lat_addr_r;
    logic [DATA_WIDTH-1:0] lat_wdata_r;
    logic [1:0]            settle_r;
    logic                  err_overflow_r;

    logic                  seq_own_s;
    logic                  seq_en_s;
    logic                  seq_we_s;
    logic                  ser_load_s;
    logic [DATA_WIDTH-1:0] ser_word_s;
    logic [IDX_BITS-1:0]   ser_last_s;
    logic                  byte_sent_s;
    logic                  last_byte_s;

    // Stall and busy cover every non-idle state, so both drop together the
    // cycle the state register returns to IDLE.
    assign cpu_stall    = (state_r != IDLE);
    assign busy         = (state_r != IDLE);
    assign err_overflow = err_overflow_r;

    uart_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_BITS   (IDX_BITS)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load_s),
        .load_word  (ser_word_s),
        .load_last  (ser_last_s),
        .send_phase (state_r == TX_SEND),
        .wait_phase (state_r == TX_WAIT),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .byte_sent  (byte_sent_s),
        .last_byte  (last_byte_s)
    );

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch: only an idle sequencer accepts a new command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_rw_r    <= 1'b0;
            lat_sel_r   <= MEM_SEL_IMEM;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
        end else if (cmd_valid && (state_r == IDLE)) begin
            lat_rw_r    <= cmd_rw;
            lat_sel_r   <= cmd_mem_type;
            lat_addr_r  <= cmd_addr;
            lat_wdata_r <= cmd_wdata;
        end
    end

    // Sticky overflow flag: a command arriving while busy is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow_r <= 1'b0;
        end else if (cmd_valid && (state_r != IDLE)) begin
            err_overflow_r <= 1'b1;
        end
    end

    // Settle counter gives the CPU pipeline time to freeze before the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_r <= 2'd0;
        end else if (state_r == STALL) begin
            settle_r <= settle_r + 2'd1;
        end else begin
            settle_r <= 2'd0;
        end
    end

    // Next-state logic and sequencer-side memory / serializer controls.
    always_comb begin
        state_s    = state_r;
        seq_own_s  = 1'b0;
        seq_en_s   = 1'b0;
        seq_we_s   = 1'b0;
        ser_load_s = 1'b0;
        ser_word_s = mem_rdata;
        ser_last_s = IDX_BITS'(NBYTES - 1);
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_s = STALL;
                end else begin
                    state_s = IDLE;
                end
            end
            STALL: begin
                if (settle_r == SETTLE_LAST) begin
                    state_s = ACCESS;
                end else begin
                    state_s = STALL;
                end
            end
            ACCESS: begin
                seq_own_s = 1'b1;
                seq_en_s  = 1'b1;
                seq_we_s  = lat_rw_r;
                if (lat_rw_r) begin
`ifdef UART_SEQ_WRITE_ACK_EN
                    ser_load_s                       = 1'b1;
                    ser_word_s                       = '0;
                    ser_word_s[DATA_WIDTH-1 -: 8]    = ACK_BYTE;
                    ser_last_s                       = '0;
                    state_s                          = TX_SEND;
`else
                    state_s = IDLE;
`endif
                end else begin
                    state_s = RDWAIT;
                end
            end
            RDWAIT: begin
                seq_own_s  = 1'b1;
                ser_load_s = 1'b1;
                state_s    = TX_SEND;
            end
            TX_SEND: begin
                seq_own_s = 1'b1;
                if (tx_start) begin
                    state_s = TX_WAIT;
                end else begin
                    state_s = TX_SEND;
                end
            end
            TX_WAIT: begin
                seq_own_s = 1'b1;
                if (byte_sent_s) begin
                    if (last_byte_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = TX_SEND;
                    end
                end else begin
                    state_s = TX_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Memory port mux: CPU passes straight through unless the sequencer owns it.
    always_comb begin
        mem_en    = cpu_mem_en;
        mem_we    = cpu_mem_we;
        mem_sel   = cpu_mem_sel;
        mem_addr  = cpu_mem_addr;
        mem_wdata = cpu_mem_wdata;
        if (seq_own_s) begin
            mem_en    = seq_en_s;
            mem_we    = seq_we_s;
            mem_sel   = lat_sel_r;
            mem_addr  = lat_addr_r;
            mem_wdata = lat_wdata_r;
        end else begin
            mem_en    = cpu_mem_en;
            mem_we    = cpu_mem_we;
            mem_sel   = cpu_mem_sel;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
        end
    end

endmodule
